fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side drain stage placed directly downstream of the team's 16-bit, 8-deep synchronous FIFO. It issues rd_en against the FIFO's empty flag and absorbs the FIFO's one-cycle read latency in a small skid buffer. It presents the data as a valid/ready stream to the next consumer. It also counts delivered words and latches any FIFO underflow as a sticky error.

Parameters:
FIFO_WIDTH, 16, data width; must match the upstream FIFO.
SKID_DEPTH, 3, skid buffer entries; minimum 3 for one word per cycle with no m_ready→rd_en path.
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits new FIFO reads
clr  input  1  synchronous clear of rd_count and underflow_err
fifo_empty  input  1  FIFO empty flag
fifo_underflow  input  1  FIFO underflow flag; valid in the cycle after an rd_en
fifo_data_out  input  FIFO_WIDTH  FIFO read data; valid in the cycle after an accepted rd_en
fifo_rd_en  output  1  read strobe to the FIFO
m_valid  output  1  stream data valid
m_ready  input  1  stream consumer ready
m_data  output  FIFO_WIDTH  stream data (head of skid buffer)
rd_count  output  CNT_W  words delivered on stream (m_valid && m_ready), wraps
underflow_err  output  1  sticky; set on any observed fifo_underflow

Behaviour:
- Reset (async, rst_n=0): clears skid buffer pointers, occupancy, inflight, rd_count and underflow_err. m_valid=0, fifo_rd_en=0 immediately (not clock-gated); m_data=0.
- State:
  - occ: 0..SKID_DEPTH, buffer occupancy.
  - inflight: 1 bit, registered copy of last cycle's fifo_rd_en.
- fifo_rd_en = enable && !fifo_empty && (occ + inflight) < SKID_DEPTH.
  - Combinational from registered state plus enable and fifo_empty only.
  - No path from m_ready to fifo_rd_en.
- Never asserts fifo_rd_en while fifo_empty=1.
- Capture: in a cycle with inflight=1:
  - fifo_underflow=0: write fifo_data_out at the write pointer.
  - fifo_underflow=1: no write; set underflow_err.
- Pop: m_valid = (occ != 0); m_data = entry at the read pointer; pop when m_valid && m_ready.
- Simultaneous capture and pop: occ unchanged, both pointers advance. Pointers wrap modulo SKID_DEPTH.
- Occupancy bound: occ + inflight never exceeds SKID_DEPTH, so the buffer cannot overflow.
- m_data/m_valid hold stable while m_valid && !m_ready (AXI-style; no retraction).
- Throughput: with the FIFO non-empty, enable=1 and m_ready=1 held, steady state is one word per cycle.
- Latency: first m_valid appears 2 cycles after fifo_empty falls (rd_en cycle, capture edge, then valid).
- enable=0: new reads stop; an in-flight word is still captured; the buffer keeps draining to the stream.
- rd_count: +1 per pop, wraps 2^CNT_W-1 → 0.
- clr: synchronous.
  - Zeroes rd_count and underflow_err; clr has priority over a same-cycle increment or set.
  - Does not touch buffer contents.
- Reset mid-transfer: buffered and in-flight words are discarded; no word is delivered twice after reset release.
- Ordering: stream order equals FIFO read order; no word is dropped or duplicated.

Test Plan:
- FIFO preloaded with 0x0001..0x0008, enable=1, m_ready=1 → fifo_rd_en high 8 consecutive cycles; m_data 0x0001..0x0008 on 8 consecutive cycles, the first 2 cycles after rd_en starts; rd_count=8; underflow_err=0.
- Preload 8 words, m_ready=0 → exactly 3 rd_en pulses, then fifo_rd_en=0, occ=3, m_data=0x0001 held stable. Raise m_ready → remaining 5 words delivered in order, one per cycle.
- m_ready toggled 1,0,1,0 with 4 words loaded → 4 words delivered in order; m_data never changes while m_valid && !m_ready; fifo_rd_en never asserted with fifo_empty=1.
- Force fifo_underflow=1 in the cycle after an rd_en → no word captured, underflow_err=1 and sticky. clr pulse → underflow_err=0, rd_count=0.
- Deassert rst_n mid-stream with occ=2 → m_valid and fifo_rd_en fall immediately, rd_count=0. After release with enable=1 and the FIFO non-empty → streaming resumes from the next FIFO word.
- rd_count preset to 0xFFFE via 2^16-2 transfers, then 3 more → rd_count wraps to 0x0001.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side drain for the 16-bit, 8-deep synchronous FIFO. It issues reads against the empty
// flag, absorbs the FIFO read latency in a skid buffer, and presents the data as a valid/ready stream.
module fifo_rd_stream #(
   parameter int FIFO_WIDTH = 16,
   parameter int SKID_DEPTH = 3,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  clr,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic [CNT_W-1:0]      rd_count,
   output logic                  underflow_err
);

   localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int OCC_W = $clog2(SKID_DEPTH + 1);

   logic [FIFO_WIDTH-1:0] r_mem [SKID_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [OCC_W-1:0]      r_occ;
   logic                  r_inflight;
   logic [CNT_W-1:0]      r_rd_count;
   logic                  r_underflow_err;

   logic [OCC_W-1:0]      w_level;
   logic                  w_rd_en;
   logic                  w_push;
   logic                  w_pop;

   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A read is issued only when a slot is reserved for its data, counting the word still in flight.
   // Gating with rst_n makes the strobe fall as soon as reset asserts, without waiting for a clock edge.
   assign w_level = r_occ + OCC_W'(r_inflight);
   assign w_rd_en = rst_n && enable && !fifo_empty && (w_level < OCC_W'(SKID_DEPTH));
   assign w_push  = r_inflight && !fifo_underflow;
   assign w_pop   = (r_occ != '0) && m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_occ      <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         if (w_push) begin
            r_mem[r_wr_ptr] <= fifo_data_out;
            r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
         else if (!w_push && w_pop) r_occ <= r_occ - OCC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_count      <= '0;
         r_underflow_err <= 1'b0;
      end else if (clr) begin
         r_rd_count      <= '0;
         r_underflow_err <= 1'b0;
      end else begin
         if (w_pop) r_rd_count <= r_rd_count + CNT_W'(1);
         if (r_inflight && fifo_underflow) r_underflow_err <= 1'b1;
      end
   end

   assign fifo_rd_en    = w_rd_en;
   assign m_valid       = (r_occ != '0);
   assign m_data        = r_mem[r_rd_ptr];
   assign rd_count      = r_rd_count;
   assign underflow_err = r_underflow_err;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: emulates the upstream FIFO and checks a queue-based
// model of the stream on every cycle, plus fixed expectations for the directed scenarios.
module tb_fifo_rd_stream;
   localparam int W = 16;
   localparam int D = 3;

   logic         clk = 1'b0;
   logic         rst_n, enable, clr, fifo_empty, fifo_underflow;
   logic [W-1:0] fifo_data_out;
   logic         fifo_rd_en, m_valid, m_ready, underflow_err;
   logic [W-1:0] m_data, rd_count;

   always #5 clk = ~clk;

   fifo_rd_stream #(.FIFO_WIDTH(W), .SKID_DEPTH(D), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
      .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .fifo_data_out(fifo_data_out),
      .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .rd_count(rd_count), .underflow_err(underflow_err)
   );

   int checks = 0;
   int errors = 0;

   // upstream FIFO emulation
   logic [W-1:0] fifo_q[$];
   logic [W-1:0] nxt_data = '0;
   logic         nxt_uf = 1'b0;
   bit           force_uf = 1'b0;

   // reference model: words captured but not yet delivered, in order
   logic [W-1:0] exp_q[$];
   bit           m_inflight = 1'b0;
   logic [15:0]  m_cnt = '0;
   bit           m_err = 1'b0;

   int           tick_no = 0;
   bit           log_en = 1'b0;
   logic [W-1:0] pop_data[$];
   int           pop_tick[$];
   int           rden_tick[$];
   int           n_pops = 0;
   bit           prev_hold = 1'b0;
   logic [W-1:0] prev_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic exp_valid, exp_rd_en;
      @(negedge clk);
      exp_valid = (exp_q.size() != 0);
      exp_rd_en = enable && !fifo_empty && ((exp_q.size() + int'(m_inflight)) < D);
      chk("m_valid", m_valid, exp_valid);
      if (exp_valid) chk("m_data", m_data, exp_q[0]);
      chk("fifo_rd_en", fifo_rd_en, exp_rd_en);
      chk("rd_count", rd_count, m_cnt);
      chk("underflow_err", underflow_err, m_err);
      chk("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
      if (prev_hold) begin
         chk("hold_valid", m_valid, 1);
         chk("hold_data", m_data, prev_data);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (log_en) begin
         if (fifo_rd_en) rden_tick.push_back(tick_no);
         if (m_valid && m_ready) begin
            pop_data.push_back(m_data);
            pop_tick.push_back(tick_no);
         end
      end
      if (exp_valid && m_ready) begin
         void'(exp_q.pop_front());
         n_pops++;
         m_cnt++;
      end
      if (m_inflight) begin
         if (fifo_underflow) m_err = 1'b1;
         else exp_q.push_back(fifo_data_out);
      end
      if (clr) begin
         m_cnt = '0;
         m_err = 1'b0;
      end
      m_inflight = exp_rd_en;
      nxt_uf = 1'b0;
      if (fifo_rd_en && fifo_q.size() != 0) begin
         nxt_data = fifo_q.pop_front();
         nxt_uf   = force_uf;
         force_uf = 1'b0;
      end
      tick_no++;
      @(posedge clk);
      #1;
      fifo_data_out  = nxt_data;
      fifo_underflow = nxt_uf;
      fifo_empty     = (fifo_q.size() == 0);
   endtask

   task automatic push_word(input logic [W-1:0] v);
      fifo_q.push_back(v);
      fifo_empty = 1'b0;
   endtask

   task automatic log_clear();
      pop_data.delete();
      pop_tick.delete();
      rden_tick.delete();
      n_pops = 0;
      log_en = 1'b1;
   endtask

   task automatic run_until(input int target, input int budget, input string name);
      int b = 0;
      while (n_pops < target && b < budget) begin
         tick();
         b++;
      end
      chk(name, n_pops, target);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; enable = 1'b0; clr = 1'b0; m_ready = 1'b0;
      fifo_empty = 1'b1; fifo_underflow = 1'b0; fifo_data_out = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_m_valid", m_valid, 0);
      chk("reset_rd_en", fifo_rd_en, 0);
      chk("reset_m_data", m_data, 0);
      chk("reset_rd_count", rd_count, 0);
      chk("reset_err", underflow_err, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // full-rate drain of 8 preloaded words
      log_clear();
      for (int i = 1; i <= 8; i++) push_word(W'(i));
      enable = 1'b1; m_ready = 1'b1;
      run_until(8, 40, "s1_pops");
      repeat (3) tick();
      chk("s1_rden_pulses", rden_tick.size(), 8);
      chk("s1_rden_span", rden_tick[7] - rden_tick[0], 7);
      chk("s1_latency", pop_tick[0] - rden_tick[0], 2);
      chk("s1_pop_span", pop_tick[7] - pop_tick[0], 7);
      for (int i = 0; i < 8; i++) chk("s1_data", pop_data[i], i + 1);
      chk("s1_rd_count", rd_count, 8);
      chk("s1_err", underflow_err, 0);

      // backpressure: buffer fills to depth, head word held
      pulse_clr();
      log_clear();
      m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push_word(W'(i));
      repeat (10) tick();
      chk("s2_rden_pulses", rden_tick.size(), 3);
      chk("s2_rd_en_low", fifo_rd_en, 0);
      chk("s2_valid", m_valid, 1);
      chk("s2_head", m_data, 16'h0001);
      m_ready = 1'b1;
      run_until(8, 40, "s2_pops");
      chk("s2_pop_span", pop_tick[7] - pop_tick[0], 7);
      for (int i = 0; i < 8; i++) chk("s2_data", pop_data[i], i + 1);
      repeat (3) tick();

      // alternating ready
      log_clear();
      for (int i = 0; i < 4; i++) push_word(W'(16'h0031 + i));
      begin
         int k = 0;
         while (n_pops < 4 && k < 40) begin
            m_ready = (k % 2 == 0);
            tick();
            k++;
         end
      end
      chk("s3_pops", n_pops, 4);
      for (int i = 0; i < 4; i++) chk("s3_data", pop_data[i], 16'h0031 + i);
      m_ready = 1'b1;
      repeat (3) tick();

      // forced underflow on the first read drops that word and sets the sticky flag
      enable = 1'b0;
      log_clear();
      push_word(16'h000A);
      push_word(16'h000B);
      force_uf = 1'b1;
      enable = 1'b1;
      repeat (10) tick();
      chk("s4_pops", n_pops, 1);
      chk("s4_data", pop_data[0], 16'h000B);
      chk("s4_err_set", underflow_err, 1);
      repeat (5) tick();
      chk("s4_err_sticky", underflow_err, 1);
      pulse_clr();
      chk("s4_err_clr", underflow_err, 0);
      chk("s4_cnt_clr", rd_count, 0);

      // reset with two words buffered and a read pending
      m_ready = 1'b0;
      push_word(16'h0051);
      push_word(16'h0052);
      repeat (6) tick();
      chk("s5_valid_pre", m_valid, 1);
      push_word(16'h0053);
      push_word(16'h0054);
      push_word(16'h0055);
      #1 chk("s5_rd_en_pre", fifo_rd_en, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("s5_valid_rst", m_valid, 0);
      chk("s5_rd_en_rst", fifo_rd_en, 0);
      chk("s5_cnt_rst", rd_count, 0);
      exp_q.delete();
      m_inflight = 1'b0; m_cnt = '0; m_err = 1'b0; prev_hold = 1'b0;
      fifo_underflow = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_ready = 1'b1;
      log_clear();
      run_until(3, 30, "s5_pops");
      for (int i = 0; i < 3; i++) chk("s5_data", pop_data[i], 16'h0053 + i);
      repeat (3) tick();

      // randomized traffic
      log_en = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         enable  = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 3) != 0);
         clr     = ($urandom_range(0, 31) == 0);
         if (fifo_q.size() < 8 && $urandom_range(0, 1) == 1) push_word(W'($urandom));
         if ($urandom_range(0, 40) == 0) force_uf = 1'b1;
         tick();
      end
      clr = 1'b0; force_uf = 1'b0;

      // counter wrap
      enable = 1'b1; m_ready = 1'b1;
      pulse_clr();
      log_en = 1'b0;
      n_pops = 0;
      begin
         int b = 0;
         while (n_pops < 65534 && b < 70000) begin
            if (fifo_q.size() < 8) push_word(W'($urandom));
            tick();
            b++;
         end
         m_ready = 1'b0;
         chk("s6_pops_a", n_pops, 65534);
         chk("s6_cnt_fffe", rd_count, 16'hFFFE);
         m_ready = 1'b1;
         b = 0;
         while (n_pops < 65537 && b < 50) begin
            if (fifo_q.size() < 8) push_word(W'($urandom));
            tick();
            b++;
         end
         m_ready = 1'b0;
         chk("s6_pops_b", n_pops, 65537);
         chk("s6_cnt_wrap", rd_count, 16'h0001);
      end
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
